// File: rtl/mem_access_unit.sv
// Memory-side access stage: sequences fetch/load/store requests onto a synchronous
// single-port SRAM with optional wait states, and holds the IR and MDR.
module mem_access_unit #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic              iwrite,
  input  logic              adrsrc,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr_q,
  output logic [DATA_W-1:0] mdr_q,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             accept_c;
  logic             is_wr;
  logic             is_iw;
  logic             wr_n;

  // State and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state; a simultaneous read and write resolves to the write
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    accept_c = 1'b0;
    wr_n     = is_wr;
    case (state)
      IDLE: begin
        if (req_rd || req_wr) begin
          accept_c = 1'b1;
          wr_n     = req_wr;
          state_n  = ACCESS;
          cnt_n    = CNT_W'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (cnt == '0) state_n = DONE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered SRAM strobes and status follow the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      is_wr     <= 1'b0;
      is_iw     <= 1'b0;
      instr_q   <= '0;
      mdr_q     <= '0;
    end else begin
      if (accept_c) begin
        mem_addr  <= adrsrc ? alu_addr : pc_addr;
        mem_wdata <= wdata;
        is_wr     <= req_wr;
        is_iw     <= iwrite;
      end
      mem_re <= (state_n == ACCESS) && !wr_n;
      mem_we <= (state_n == ACCESS) && wr_n;
      busy   <= (state_n != IDLE);
      done   <= (state_n == DONE);
      if ((state == DONE) && !is_wr) begin
        if (is_iw) instr_q <= mem_rdata;
        else       mdr_q   <= mem_rdata;
      end
    end
  end

endmodule
